// File: rtl/axi_read_arbiter_rr_if.sv
// axi_read_arbiter_rr_if: cache-master request/data side plus the single AXI read channel
interface axi_read_arbiter_rr_if #(
  parameter int READ_MASTERS = 3,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4
);
  logic [READ_MASTERS-1:0]            m_arvalid;
  logic [READ_MASTERS*ADDR_WIDTH-1:0] m_araddr;
  logic [READ_MASTERS*4-1:0]          m_arlen;
  logic [READ_MASTERS-1:0]            m_arready;
  logic [READ_MASTERS-1:0]            m_rvalid;
  logic [READ_MASTERS-1:0]            m_rlast;
  logic [DATA_WIDTH-1:0]              m_rdata;
  logic [READ_MASTERS-1:0]            m_rready;
  logic                               ARVALID;
  logic [ID_WIDTH-1:0]                ARID;
  logic [3:0]                         ARLEN;
  logic [ADDR_WIDTH-1:0]              ARADDR;
  logic                               ARREADY;
  logic                               RVALID;
  logic                               RLAST;
  logic [ID_WIDTH-1:0]                RID;
  logic [DATA_WIDTH-1:0]              RDATA;
  logic                               RREADY;
  // arbiter view: it is the AXI master towards memory and the slave towards the caches
  modport master (
    input  m_arvalid, m_araddr, m_arlen, m_rready, ARREADY, RVALID, RLAST, RID, RDATA,
    output m_arready, m_rvalid, m_rlast, m_rdata, ARVALID, ARID, ARLEN, ARADDR, RREADY
  );
  // environment view: cache masters plus the memory-side AXI slave
  modport slave (
    output m_arvalid, m_araddr, m_arlen, m_rready, ARREADY, RVALID, RLAST, RID, RDATA,
    input  m_arready, m_rvalid, m_rlast, m_rdata, ARVALID, ARID, ARLEN, ARADDR, RREADY
  );
endinterface

// File: rtl/axi_read_arbiter_rr.sv
// axi_read_arbiter_rr: N-master AXI read arbiter, round-robin or fixed priority, one burst in flight
module axi_read_arbiter_rr #(
  parameter int READ_MASTERS = 3,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int RR_MODE      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_read_arbiter_rr_if.master bus,
  output logic                 busy,
  output logic                 proto_err
);
  localparam int IW = $clog2(READ_MASTERS);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                r_state;
  logic [IW-1:0]         r_rr_ptr, r_grant_idx;
  logic [3:0]            r_beat_cnt, r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_arvalid, r_proto_err;
  logic [IW-1:0]         w_winner;
  logic                  w_req, w_rready, w_beat, w_bad;
  // first requester at or after ptr (round-robin) or lowest requester (fixed priority)
  function automatic logic [IW-1:0] pick(input logic [READ_MASTERS-1:0] req, input logic [IW-1:0] ptr);
    logic found;
    int   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < READ_MASTERS; k++) begin
      idx = (RR_MODE != 0) ? (int'(ptr) + k) % READ_MASTERS : k;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  endfunction
  assign w_req    = |bus.m_arvalid;
  assign w_winner = pick(bus.m_arvalid, r_rr_ptr);
  assign w_rready = r_state == DATA && bus.m_rready[r_grant_idx];
  assign w_beat   = w_rready && bus.RVALID;
  assign w_bad    = bus.RID != ID_WIDTH'(r_grant_idx) || bus.RLAST != (r_beat_cnt == r_len);
  // arbitration FSM: latch the winner in IDLE, hold the address until ARREADY, forward beats until RLAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_beat_cnt  <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_arvalid   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_beat && w_bad;
      if (r_state == IDLE) begin
        if (w_req) begin
          r_state     <= ADDR;
          r_arvalid   <= 1'b1;
          r_grant_idx <= w_winner;
          r_addr      <= bus.m_araddr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
          r_len       <= bus.m_arlen[w_winner*4 +: 4];
        end
      end else if (r_state == ADDR) begin
        if (bus.ARREADY) begin
          r_state    <= DATA;
          r_arvalid  <= 1'b0;
          r_beat_cnt <= '0;
        end
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
        if (bus.RLAST) begin
          r_state  <= IDLE;
          r_rr_ptr <= (r_grant_idx == IW'(READ_MASTERS - 1)) ? '0 : r_grant_idx + 1'b1;
        end
      end
    end
  end
  assign bus.ARVALID   = r_arvalid;
  assign bus.ARID      = ID_WIDTH'(r_grant_idx);
  assign bus.ARLEN     = r_len;
  assign bus.ARADDR    = r_addr;
  assign bus.RREADY    = w_rready;
  assign bus.m_arready = {{(READ_MASTERS-1){1'b0}}, r_state == ADDR && bus.ARREADY} << r_grant_idx;
  assign bus.m_rvalid  = {{(READ_MASTERS-1){1'b0}}, r_state == DATA && bus.RVALID} << r_grant_idx;
  assign bus.m_rlast   = {{(READ_MASTERS-1){1'b0}}, r_state == DATA && bus.RLAST} << r_grant_idx;
  assign bus.m_rdata   = r_state == DATA ? bus.RDATA : '0;
  assign busy          = r_state != IDLE;
  assign proto_err     = r_proto_err;
endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// tb_axi_read_arbiter_rr: directed bench with AXI slave models and a beat scoreboard
module tb_axi_read_arbiter_rr;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  axi_read_arbiter_rr_if #(.READ_MASTERS(3)) ia();
  axi_read_arbiter_rr_if #(.READ_MASTERS(3)) ib();
  axi_read_arbiter_rr_if #(.READ_MASTERS(8)) ic();
  logic busy_a, perr_a, busy_b, perr_b, busy_c, perr_c;
  axi_read_arbiter_rr #(.READ_MASTERS(3), .RR_MODE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia), .busy(busy_a), .proto_err(perr_a));
  axi_read_arbiter_rr #(.READ_MASTERS(3), .RR_MODE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib), .busy(busy_b), .proto_err(perr_b));
  axi_read_arbiter_rr #(.READ_MASTERS(8), .RR_MODE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic), .busy(busy_c), .proto_err(perr_c));
  function automatic logic [31:0] rdat(input logic [3:0] id, input logic [3:0] b);
    return {16'hA5A5, 4'h0, id, 4'h0, b};
  endfunction
  // slave A with knobs: address backpressure, a wrong RID on one beat, an early RLAST
  logic       sa_pend;
  logic [3:0] sa_len, sa_id, sa_cnt;
  logic       ka_ardy = 1'b1;
  logic [3:0] ka_badid = 4'hF, ka_last = 4'hF;
  assign ia.ARREADY = ka_ardy;
  assign ia.RVALID  = sa_pend;
  assign ia.RID     = (sa_cnt == ka_badid) ? 4'd2 : sa_id;
  assign ia.RLAST   = sa_pend && sa_cnt == (ka_last == 4'hF ? sa_len : ka_last);
  assign ia.RDATA   = rdat(sa_id, sa_cnt);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_pend <= 1'b0; sa_len <= '0; sa_id <= '0; sa_cnt <= '0;
    end else if (ia.ARVALID && ia.ARREADY) begin
      sa_pend <= 1'b1; sa_len <= ia.ARLEN; sa_id <= ia.ARID; sa_cnt <= '0;
    end else if (sa_pend && ia.RREADY) begin
      sa_cnt <= sa_cnt + 4'd1;
      if (ia.RLAST) sa_pend <= 1'b0;
    end
  end
  // slaves B and C: always ready, well-formed bursts
  logic       sb_pend, sc_pend;
  logic [3:0] sb_len, sb_id, sb_cnt, sc_len, sc_id, sc_cnt;
  assign ib.ARREADY = 1'b1;
  assign ib.RVALID  = sb_pend;
  assign ib.RID     = sb_id;
  assign ib.RLAST   = sb_pend && sb_cnt == sb_len;
  assign ib.RDATA   = rdat(sb_id, sb_cnt);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_pend <= 1'b0; sb_len <= '0; sb_id <= '0; sb_cnt <= '0;
    end else if (ib.ARVALID && ib.ARREADY) begin
      sb_pend <= 1'b1; sb_len <= ib.ARLEN; sb_id <= ib.ARID; sb_cnt <= '0;
    end else if (sb_pend && ib.RREADY) begin
      sb_cnt <= sb_cnt + 4'd1;
      if (ib.RLAST) sb_pend <= 1'b0;
    end
  end
  assign ic.ARREADY = 1'b1;
  assign ic.RVALID  = sc_pend;
  assign ic.RID     = sc_id;
  assign ic.RLAST   = sc_pend && sc_cnt == sc_len;
  assign ic.RDATA   = rdat(sc_id, sc_cnt);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_pend <= 1'b0; sc_len <= '0; sc_id <= '0; sc_cnt <= '0;
    end else if (ic.ARVALID && ic.ARREADY) begin
      sc_pend <= 1'b1; sc_len <= ic.ARLEN; sc_id <= ic.ARID; sc_cnt <= '0;
    end else if (sc_pend && ic.RREADY) begin
      sc_cnt <= sc_cnt + 4'd1;
      if (ic.RLAST) sc_pend <= 1'b0;
    end
  end
  // scoreboard of {master, data, last} for every beat dut_a should hand out
  logic [36:0] sbq[$];
  logic [36:0] mon_act, mon_exp;
  bit          sb_on = 1'b0;
  task automatic push(input int m, input int b, input bit last);
    sbq.push_back({4'(m), rdat(4'(m), 4'(b)), last});
  endtask
  always @(negedge clk) begin
    if (sb_on) begin
      for (int i = 0; i < 3; i++) begin
        if (ia.m_rvalid[i] && ia.m_rready[i]) begin
          mon_act = {4'(i), ia.m_rdata, ia.m_rlast[i]};
          mon_exp = (sbq.size() != 0) ? sbq.pop_front() : '1;
          checks++;
          assert (mon_act === mon_exp) else begin
            errors++;
            $error("FAIL beat observed=%h expected=%h", mon_act, mon_exp);
          end
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    ia.m_arvalid = '0; ia.m_araddr = '0; ia.m_arlen = '0; ia.m_rready = '0;
    ib.m_arvalid = '0; ib.m_araddr = '0; ib.m_arlen = '0; ib.m_rready = '0;
    ic.m_arvalid = '0; ic.m_araddr = '0; ic.m_arlen = '0; ic.m_rready = '0;
    ka_ardy = 1'b1; ka_badid = 4'hF; ka_last = 4'hF;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    sb_on = 1'b0;
    sbq.delete();
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int g0;
    bit seen2;
    clear_inputs();
    // reset state, one-cycle arbitration latency, reset mid-burst
    do_reset();
    chk("rst_arvalid", ia.ARVALID, 0);
    chk("rst_busy", busy_a, 0);
    ia.m_araddr[0 +: 26] = 26'h100;
    ia.m_arlen[3:0] = 4'd1;
    ia.m_rready = 3'b111;
    ia.m_arvalid = 3'b001;
    #1 chk("lat0_arvalid", ia.ARVALID, 0);
    tick();
    chk("lat1_arvalid", ia.ARVALID, 1);
    chk("lat1_arid", ia.ARID, 0);
    chk("lat1_araddr", ia.ARADDR, 26'h100);
    chk("lat1_arlen", ia.ARLEN, 1);
    chk("lat1_arready", ia.m_arready, 3'b001);
    ia.m_arvalid = '0;
    tick();
    chk("data_rvalid", ia.m_rvalid, 3'b001);
    chk("data_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_arvalid", ia.ARVALID, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_rvalid", ia.m_rvalid, 0);
    chk("arst_rlast", ia.m_rlast, 0);
    chk("arst_rready", ia.RREADY, 0);
    chk("arst_rdata", ia.m_rdata, 0);
    chk("arst_araddr", ia.ARADDR, 0);
    chk("arst_perr", perr_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // round-robin fairness: three masters hold requests, four-beat bursts
    do_reset();
    ia.m_araddr = {26'h300, 26'h200, 26'h100};
    ia.m_arlen = {4'd3, 4'd3, 4'd3};
    ia.m_rready = 3'b111;
    sb_on = 1'b1;
    for (int n = 0; n < 4; n++) for (int b = 0; b < 4; b++) push(n % 3, b, b == 3);
    ia.m_arvalid = 3'b111;
    for (int t = 0; t < 200 && sbq.size() != 0; t++) tick();
    ia.m_arvalid = '0;
    chk("rr_drained", sbq.size(), 0);
    repeat (4) tick();
    chk("rr_idle_busy", busy_a, 0);
    chk("rr_idle_arvalid", ia.ARVALID, 0);
    // address backpressure then toggling data ready on master 1
    do_reset();
    sb_on = 1'b1;
    ka_ardy = 1'b0;
    for (int b = 0; b < 4; b++) push(1, b, b == 3);
    ia.m_araddr[26 +: 26] = 26'h2A0;
    ia.m_arlen[7:4] = 4'd3;
    ia.m_rready = 3'b010;
    ia.m_arvalid = 3'b010;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_arvalid", ia.ARVALID, 1);
      chk("bp_araddr", ia.ARADDR, 26'h2A0);
      chk("bp_arready0", ia.m_arready, 0);
      tick();
    end
    ka_ardy = 1'b1;
    #1 chk("bp_arready1", ia.m_arready, 3'b010);
    ia.m_arvalid = '0;
    for (int i = 0; i < 16 && sbq.size() != 0; i++) begin
      tick();
      ia.m_rready[1] = i[0];
      #1 chk("bp_rready", ia.RREADY, (sbq.size() != 0) && i[0]);
    end
    chk("bp_drained", sbq.size(), 0);
    // protocol errors: wrong RID on beat 1, early RLAST on beat 2 of a four-beat burst
    do_reset();
    sb_on = 1'b1;
    ka_badid = 4'd0;
    ka_last = 4'd1;
    push(1, 0, 1'b0);
    push(1, 1, 1'b1);
    ia.m_arlen[7:4] = 4'd3;
    ia.m_rready = 3'b010;
    ia.m_arvalid = 3'b010;
    tick();
    chk("pe_arid", ia.ARID, 1);
    ia.m_arvalid = '0;
    tick();
    chk("pe_quiet", perr_a, 0);
    tick();
    chk("pe_pulse1", perr_a, 1);
    ia.m_rready = '0;
    tick();
    chk("pe_gap", perr_a, 0);
    chk("pe_busy", busy_a, 1);
    ia.m_rready = 3'b010;
    tick();
    chk("pe_pulse2", perr_a, 1);
    chk("pe_idle", busy_a, 0);
    tick();
    chk("pe_end", perr_a, 0);
    chk("pe_drained", sbq.size(), 0);
    // fixed priority: master 2 starves while master 0 keeps requesting
    do_reset();
    ib.m_araddr[0 +: 26] = 26'h40;
    ib.m_araddr[52 +: 26] = 26'h80;
    ib.m_arlen = {4'd1, 4'd0, 4'd1};
    ib.m_rready = 3'b111;
    ib.m_arvalid = 3'b101;
    g0 = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ib.ARVALID) begin
        chk("fp_arid", ib.ARID, 0);
        g0++;
      end
    end
    chk("fp_grants", g0 >= 14, 1);
    ib.m_arvalid = 3'b100;
    seen2 = 1'b0;
    for (int i = 0; i < 20 && !seen2; i++) begin
      tick();
      if (ib.ARVALID && ib.ARID == 4'd2) seen2 = 1'b1;
    end
    chk("fp_m2_after", seen2, 1);
    chk("fp_m2_addr", ib.ARADDR, 26'h80);
    ib.m_arvalid = '0;
    // eight masters: pointer wraps 7 -> 0 -> 1
    do_reset();
    ic.m_araddr[7*26 +: 26] = 26'h700;
    ic.m_araddr[0 +: 26] = 26'h10;
    ic.m_araddr[26 +: 26] = 26'h20;
    ic.m_rready = '1;
    ic.m_arvalid = 8'h80;
    for (int i = 0; i < 10 && !ic.ARVALID; i++) tick();
    chk("w_arid7", ic.ARID, 7);
    chk("w_addr7", ic.ARADDR, 26'h700);
    ic.m_arvalid = 8'h81;
    tick();
    for (int i = 0; i < 10 && !ic.ARVALID; i++) tick();
    chk("w_arid0", ic.ARID, 0);
    chk("w_addr0", ic.ARADDR, 26'h10);
    ic.m_arvalid = 8'h83;
    tick();
    for (int i = 0; i < 10 && !ic.ARVALID; i++) tick();
    chk("w_arid1", ic.ARID, 1);
    chk("w_addr1", ic.ARADDR, 26'h20);
    ic.m_arvalid = '0;
    repeat (5) tick();
    chk("w_idle", busy_c, 0);
    chk("w_perr", perr_c, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
